// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mode_sequencer
// Description : Button-driven mode / time-set editor / run-flag sequencer
//               for the multimode clock.
// Revision    : 1.0  initial release
// ============================================================================
module mode_sequencer #(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       ss_btn,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [1:0] mode,
    output logic [1:0] edit_field,
    output logic [7:0] edit_hours,
    output logic [7:0] edit_minutes,
    output logic [7:0] edit_seconds,
    output logic       load,
    output logic       run_timer,
    output logic       run_stopwatch,
    output logic       blink
);

    localparam int                 c_CNT_W   = $clog2(BLINK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]         c_MAX_HR  = 8'h23;
    localparam logic [7:0]         c_MAX_MS  = 8'h59;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_EDIT_H = 2'd1,
        S_EDIT_M = 2'd2,
        S_EDIT_S = 2'd3
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [1:0]           r_mode,    w_mode_nxt;
    logic [7:0]           r_eh,      w_eh_nxt;
    logic [7:0]           r_em,      w_em_nxt;
    logic [7:0]           r_es,      w_es_nxt;
    logic                 r_load,    w_load_nxt;
    logic                 r_run_t,   w_run_t_nxt;
    logic                 r_run_sw,  w_run_sw_nxt;
    logic                 r_blink,   w_blink_nxt;
    logic [c_CNT_W-1:0]   r_bcnt,    w_bcnt_nxt;
    logic                 r_mode_p, r_set_p, r_inc_p, r_ss_p;
    logic                 w_mode_e, w_set_e, w_inc_e, w_ss_e;

    // Non-BCD digits or out-of-range values collapse to 00 on capture.
    function automatic logic [7:0] f_sanitise(input logic [7:0] v, input logic [7:0] max);
        if ((v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v > max)) begin
            return 8'h00;
        end
        return v;
    endfunction

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_mode_e = mode_btn & ~r_mode_p;
    assign w_set_e  = set_btn  & ~r_set_p;
    assign w_inc_e  = inc_btn  & ~r_inc_p;
    assign w_ss_e   = ss_btn   & ~r_ss_p;

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_eh_nxt     = r_eh;
        w_em_nxt     = r_em;
        w_es_nxt     = r_es;
        w_load_nxt   = 1'b0;
        w_run_t_nxt  = r_run_t;
        w_run_sw_nxt = r_run_sw;
        w_blink_nxt  = 1'b0;
        w_bcnt_nxt   = '0;

        if (r_state != S_RUN) begin
            if (r_bcnt == c_CNT_MAX) begin
                w_bcnt_nxt  = '0;
                w_blink_nxt = ~r_blink;
            end else begin
                w_bcnt_nxt  = r_bcnt + 1'b1;
                w_blink_nxt = r_blink;
            end
        end

        case (r_state)
            S_RUN: begin
                if (w_mode_e) begin
                    w_mode_nxt = r_mode + 2'd1;
                end else if (w_set_e) begin
                    if (r_mode != 2'd3) begin
                        w_state_nxt = S_EDIT_H;
                        w_eh_nxt    = f_sanitise(cur_hours,   c_MAX_HR);
                        w_em_nxt    = f_sanitise(cur_minutes, c_MAX_MS);
                        w_es_nxt    = f_sanitise(cur_seconds, c_MAX_MS);
                        w_run_t_nxt = 1'b0;
                        w_blink_nxt = 1'b1;
                        w_bcnt_nxt  = '0;
                    end
                end else if (w_ss_e) begin
                    if (r_mode == 2'd2) begin
                        w_run_t_nxt = ~r_run_t;
                    end else if (r_mode == 2'd3) begin
                        w_run_sw_nxt = ~r_run_sw;
                    end
                end
            end
            default: begin
                if (w_mode_e) begin
                    w_state_nxt = S_RUN;
                    w_blink_nxt = 1'b0;
                    w_bcnt_nxt  = '0;
                end else if (w_set_e) begin
                    // Each field advance restarts the blink phase visible.
                    w_blink_nxt = 1'b1;
                    w_bcnt_nxt  = '0;
                    case (r_state)
                        S_EDIT_H: w_state_nxt = S_EDIT_M;
                        S_EDIT_M: w_state_nxt = S_EDIT_S;
                        default: begin
                            w_state_nxt = S_RUN;
                            w_load_nxt  = 1'b1;
                            w_blink_nxt = 1'b0;
                        end
                    endcase
                end else if (w_inc_e) begin
                    case (r_state)
                        S_EDIT_H: w_eh_nxt = f_bcd_inc(r_eh, c_MAX_HR);
                        S_EDIT_M: w_em_nxt = f_bcd_inc(r_em, c_MAX_MS);
                        default:  w_es_nxt = f_bcd_inc(r_es, c_MAX_MS);
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            r_state  <= S_RUN;
            r_mode   <= 2'd0;
            r_eh     <= 8'h00;
            r_em     <= 8'h00;
            r_es     <= 8'h00;
            r_load   <= 1'b0;
            r_run_t  <= 1'b0;
            r_run_sw <= 1'b0;
            r_blink  <= 1'b0;
            r_bcnt   <= '0;
            r_mode_p <= 1'b0;
            r_set_p  <= 1'b0;
            r_inc_p  <= 1'b0;
            r_ss_p   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_eh     <= w_eh_nxt;
            r_em     <= w_em_nxt;
            r_es     <= w_es_nxt;
            r_load   <= w_load_nxt;
            r_run_t  <= w_run_t_nxt;
            r_run_sw <= w_run_sw_nxt;
            r_blink  <= w_blink_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_mode_p <= mode_btn;
            r_set_p  <= set_btn;
            r_inc_p  <= inc_btn;
            r_ss_p   <= ss_btn;
        end
    end

    assign mode          = r_mode;
    assign edit_field    = r_state;
    assign edit_hours    = r_eh;
    assign edit_minutes  = r_em;
    assign edit_seconds  = r_es;
    assign load          = r_load;
    assign run_timer     = r_run_t;
    assign run_stopwatch = r_run_sw;
    assign blink         = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_sequencer
// Description : Self-checking bench for mode_sequencer (BLINK_DIV = 4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mode_sequencer;

    localparam int c_DIV = 4;
    localparam int c_MODE = 0, c_SET = 1, c_INC = 2, c_SS = 3;

    logic       CLK, RST_BTN;
    logic       mode_btn, set_btn, inc_btn, ss_btn;
    logic [7:0] cur_hours, cur_minutes, cur_seconds;
    logic [1:0] mode, edit_field;
    logic [7:0] edit_hours, edit_minutes, edit_seconds;
    logic       load, run_timer, run_stopwatch, blink;

    int checks = 0;
    int errors = 0;
    int load_seen = 0;
    bit cmp_en = 0;

    mode_sequencer #(.BLINK_DIV(c_DIV)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN),
        .mode_btn(mode_btn), .set_btn(set_btn), .inc_btn(inc_btn), .ss_btn(ss_btn),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .mode(mode), .edit_field(edit_field),
        .edit_hours(edit_hours), .edit_minutes(edit_minutes), .edit_seconds(edit_seconds),
        .load(load), .run_timer(run_timer), .run_stopwatch(run_stopwatch), .blink(blink)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: times held as plain integers, blink derived from cycles since
    // the current field was entered.
    int m_mode = 0, m_field = 0, m_h = 0, m_m = 0, m_s = 0, m_since = 0;
    bit m_load = 0, m_rt = 0, m_rsw = 0;
    bit p_mode = 0, p_set = 0, p_inc = 0, p_ss = 0;

    function automatic int san(input logic [7:0] v, input int max);
        int hi = int'(v[7:4]);
        int lo = int'(v[3:0]);
        if (hi > 9 || lo > 9) return 0;
        if (hi * 10 + lo > max) return 0;
        return hi * 10 + lo;
    endfunction

    function automatic int bcd(input int x);
        return ((x / 10) * 16) + (x % 10);
    endfunction

    always @(posedge CLK) begin
        bit em, es, ei, ess;
        if (RST_BTN) begin
            m_mode = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_since = 0;
            m_load = 0; m_rt = 0; m_rsw = 0;
            p_mode = 0; p_set = 0; p_inc = 0; p_ss = 0;
        end else begin
            em  = mode_btn && !p_mode;
            es  = set_btn  && !p_set;
            ei  = inc_btn  && !p_inc;
            ess = ss_btn   && !p_ss;
            m_load = 0;
            if (m_field != 0) m_since++;
            if (em) begin
                if (m_field == 0) m_mode = (m_mode + 1) % 4;
                else              m_field = 0;
            end else if (es) begin
                if (m_field == 0) begin
                    if (m_mode != 3) begin
                        m_field = 1; m_since = 0; m_rt = 0;
                        m_h = san(cur_hours, 23);
                        m_m = san(cur_minutes, 59);
                        m_s = san(cur_seconds, 59);
                    end
                end else if (m_field == 3) begin
                    m_field = 0; m_load = 1;
                end else begin
                    m_field++; m_since = 0;
                end
            end else if (ei) begin
                if (m_field == 1)      m_h = (m_h + 1) % 24;
                else if (m_field == 2) m_m = (m_m + 1) % 60;
                else if (m_field == 3) m_s = (m_s + 1) % 60;
            end else if (ess && m_field == 0) begin
                if (m_mode == 2)      m_rt  = !m_rt;
                else if (m_mode == 3) m_rsw = !m_rsw;
            end
            p_mode = mode_btn; p_set = set_btn; p_inc = inc_btn; p_ss = ss_btn;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("mode",          int'(mode),          m_mode);
            chk("edit_field",    int'(edit_field),    m_field);
            chk("edit_hours",    int'(edit_hours),    bcd(m_h));
            chk("edit_minutes",  int'(edit_minutes),  bcd(m_m));
            chk("edit_seconds",  int'(edit_seconds),  bcd(m_s));
            chk("load",          int'(load),          int'(m_load));
            chk("run_timer",     int'(run_timer),     int'(m_rt));
            chk("run_stopwatch", int'(run_stopwatch), int'(m_rsw));
            chk("blink",         int'(blink),
                int'(m_field != 0 && ((m_since / c_DIV) % 2 == 0)));
            if (load) load_seen++;
        end
    end

    task automatic drive(input int which, input logic v);
        case (which)
            c_MODE:  mode_btn = v;
            c_SET:   set_btn  = v;
            c_INC:   inc_btn  = v;
            default: ss_btn   = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        @(negedge CLK); drive(which, 1'b1);
        repeat (hold) @(negedge CLK);
        drive(which, 1'b0);
        repeat (2) @(negedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mode",  int'(mode),          0);
        chk("rst_field", int'(edit_field),    0);
        chk("rst_edit",  int'({edit_hours, edit_minutes, edit_seconds}), 0);
        chk("rst_flags", int'({load, run_timer, run_stopwatch, blink}), 0);
    endtask

    initial begin
        int mode_exp[5] = '{1, 2, 3, 0, 1};
        int blink_exp[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        RST_BTN = 1'b1;
        mode_btn = 1'b0; set_btn = 1'b0; inc_btn = 1'b0; ss_btn = 1'b0;
        cur_hours = 8'h23; cur_minutes = 8'h58; cur_seconds = 8'h59;
        repeat (3) @(negedge CLK);
        cmp_en = 1'b1;
        #1 chk_reset_outputs();
        @(negedge CLK); RST_BTN = 1'b0;

        // Mode cycling
        for (int i = 0; i < 5; i++) begin
            press(c_MODE, 2);
            chk("mode_cycle", int'(mode), mode_exp[i]);
        end
        chk("mode_cycle_field", int'(edit_field), 0);
        repeat (3) press(c_MODE, 2);
        chk("mode_back_to_0", int'(mode), 0);

        // Edit and commit from 23:58:59
        press(c_SET, 2);
        chk("cap_field", int'(edit_field), 1);
        chk("cap_hms", int'({edit_hours, edit_minutes, edit_seconds}), 'h235859);
        press(c_INC, 2);
        chk("hours_wrap", int'(edit_hours), 'h00);
        press(c_SET, 2);
        chk("field_min", int'(edit_field), 2);
        press(c_INC, 2);
        press(c_INC, 2);
        chk("min_wrap", int'(edit_minutes), 'h00);
        press(c_SET, 2);
        chk("field_sec", int'(edit_field), 3);
        press(c_INC, 2);
        press(c_SET, 2);
        chk("commit_field", int'(edit_field), 0);
        chk("commit_hms", int'({edit_hours, edit_minutes, edit_seconds}), 'h000000);
        chk("commit_loads", load_seen, 1);
        chk("commit_rt", int'(run_timer), 0);

        // Abort with out-of-range capture
        cur_hours = 8'h2A; cur_minutes = 8'h61; cur_seconds = 8'h45;
        press(c_SET, 2);
        chk("san_hms", int'({edit_hours, edit_minutes, edit_seconds}), 'h000045);
        press(c_MODE, 2);
        chk("abort_field", int'(edit_field), 0);
        chk("abort_mode", int'(mode), 0);
        chk("abort_hold", int'({edit_hours, edit_minutes, edit_seconds}), 'h000045);
        chk("abort_loads", load_seen, 1);

        // Run flags
        repeat (2) press(c_MODE, 2);
        press(c_SS, 2);
        chk("rt_on", int'(run_timer), 1);
        press(c_MODE, 2);
        press(c_SS, 2);
        chk("rsw_on", int'(run_stopwatch), 1);
        repeat (3) press(c_MODE, 2);
        chk("rt_kept", int'(run_timer), 1);
        press(c_SET, 2);
        chk("rt_cleared", int'(run_timer), 0);
        chk("rsw_kept", int'(run_stopwatch), 1);

        // Simultaneous set+inc in minutes, then a long inc hold in seconds
        press(c_SET, 2);
        @(negedge CLK); set_btn = 1'b1; inc_btn = 1'b1;
        repeat (2) @(negedge CLK);
        set_btn = 1'b0; inc_btn = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("simul_field", int'(edit_field), 3);
        chk("simul_min", int'(edit_minutes), 'h00);
        press(c_INC, 1000);
        chk("held_inc", int'(edit_seconds), 'h46);
        press(c_MODE, 2);

        // Blink sequence from edit entry
        @(negedge CLK); set_btn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK); #1;
            chk("blink_seq", int'(blink), blink_exp[i]);
            set_btn = 1'b0;
        end
        press(c_SET, 2);
        press(c_SET, 2);
        chk("pre_rst_field", int'(edit_field), 3);

        // Reset mid-edit
        @(negedge CLK); RST_BTN = 1'b1;
        @(negedge CLK); #1;
        chk_reset_outputs();
        @(negedge CLK); RST_BTN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_no_load", load_seen, 1);

        // Button held across reset release gives one edge
        @(negedge CLK); RST_BTN = 1'b1; mode_btn = 1'b1;
        repeat (2) @(negedge CLK);
        RST_BTN = 1'b0;
        repeat (3) @(negedge CLK);
        #1 chk("held_at_release", int'(mode), 1);
        mode_btn = 1'b0;
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
